// File: rtl/axi_tdd_sync_gen.sv
// TDD frame sync generator: merges external pin, software and
// periodic internal triggers into one single-cycle tdd_sync pulse.
module axi_tdd_sync_gen #(
  parameter int SYNC_COUNT_WIDTH  = 64,
  parameter bit SYNC_EXTERNAL_CDC = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        tdd_enable,
  input  logic                        tdd_sync_int,
  input  logic                        tdd_sync_ext,
  input  logic                        tdd_sync_soft,
  input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
  input  logic                        sync_in,
  output logic                        tdd_sync,
  output logic                        tdd_sync_armed,
  output logic                        tdd_sync_running
);

  localparam logic [SYNC_COUNT_WIDTH-1:0] ONE =
    SYNC_COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUNNING
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_COUNT_WIDTH-1:0] sync_period;
  logic [SYNC_COUNT_WIDTH-1:0] cnt, cnt_nxt;
  logic int_en, ext_en;
  logic s3, ext_edge;
  logic ext_trig, soft_trig, int_trig, trig;

  // Edge flops run regardless of enable, so a level already
  // high when the block is enabled never looks like an edge.
  generate
    if (SYNC_EXTERNAL_CDC) begin : g_cdc
      logic s1, s2;
      always_ff @(posedge clk) begin
        if (!resetn) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
          s3 <= 1'b0;
        end else begin
          s1 <= sync_in;
          s2 <= s1;
          s3 <= s2;
        end
      end
      assign ext_edge = s2 & ~s3;
    end else begin : g_nocdc
      always_ff @(posedge clk) begin
        if (!resetn) s3 <= 1'b0;
        else         s3 <= sync_in;
      end
      assign ext_edge = sync_in & ~s3;
    end
  endgenerate

  assign ext_trig  = ext_edge & ext_en;
  assign soft_trig = tdd_sync_soft & tdd_enable;
  assign trig      = ext_trig | soft_trig;

  // Config is only sampled while disabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_period <= '0;
      int_en      <= 1'b0;
      ext_en      <= 1'b0;
    end else if (!tdd_enable) begin
      sync_period <= asy_tdd_sync_period;
      int_en      <= tdd_sync_int;
      ext_en      <= tdd_sync_ext;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    int_trig  = 1'b0;
    if (!tdd_enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = ext_en ? ARMED : RUNNING;
        end
        ARMED: begin
          if (trig) state_nxt = RUNNING;
        end
        RUNNING: begin
          if (int_en && sync_period != '0) begin
            if (cnt == sync_period - ONE) int_trig = 1'b1;
            else                          cnt_nxt  = cnt + ONE;
          end
          // External/soft sync re-aligns the internal train.
          if (trig) cnt_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      cnt              <= '0;
      tdd_sync         <= 1'b0;
      tdd_sync_armed   <= 1'b0;
      tdd_sync_running <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      tdd_sync         <= tdd_enable & (trig | int_trig);
      tdd_sync_armed   <= (state_nxt == ARMED);
      tdd_sync_running <= (state_nxt == RUNNING);
    end
  end

endmodule

// File: tb/tb_axi_tdd_sync_gen.sv
// Bench for axi_tdd_sync_gen: edge-indexed reference model plus
// literal checks of the pulse, armed and running logs.
module tb_axi_tdd_sync_gen;

  logic        clk;
  logic        resetn;
  logic        tdd_enable;
  logic        tdd_sync_int;
  logic        tdd_sync_ext;
  logic        tdd_sync_soft;
  logic [63:0] asy_tdd_sync_period;
  logic        sync_in;
  logic        tdd_sync;
  logic        tdd_sync_armed;
  logic        tdd_sync_running;

  axi_tdd_sync_gen #(
    .SYNC_COUNT_WIDTH (64),
    .SYNC_EXTERNAL_CDC(1'b1)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .tdd_enable         (tdd_enable),
    .tdd_sync_int       (tdd_sync_int),
    .tdd_sync_ext       (tdd_sync_ext),
    .tdd_sync_soft      (tdd_sync_soft),
    .asy_tdd_sync_period(asy_tdd_sync_period),
    .sync_in            (sync_in),
    .tdd_sync           (tdd_sync),
    .tdd_sync_armed     (tdd_sync_armed),
    .tdd_sync_running   (tdd_sync_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  bit pl [0:255];
  bit ar [0:255];
  bit rn [0:255];

  // Model: mode 0 idle, 1 waiting for first sync, 2 running.
  // Internal pulses fall on anchor + k*P.
  int          m_mode = 0;
  longint      m_anchor = 0;
  longint unsigned m_per = 0;
  bit          m_int = 0, m_ext = 0;
  bit          h1 = 0, h2 = 0, h3 = 0;
  bit          e_sync = 0;

  task automatic lit(input string nm, input bit got, input bit exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    bit ext_t, soft_t, int_t;
    edge_n++;
    ext_t  = h2 && !h3 && m_ext;
    soft_t = tdd_sync_soft && tdd_enable;
    int_t  = 0;
    if (!resetn) begin
      m_mode = 0; m_per = 0; m_int = 0; m_ext = 0;
      e_sync = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      if (!tdd_enable) begin
        m_mode = 0;
        e_sync = 0;
        m_per  = asy_tdd_sync_period;
        m_int  = tdd_sync_int;
        m_ext  = tdd_sync_ext;
      end else if (m_mode == 0) begin
        m_mode   = m_ext ? 1 : 2;
        m_anchor = edge_n;
        e_sync   = ext_t || soft_t;
      end else if (m_mode == 1) begin
        e_sync = ext_t || soft_t;
        if (e_sync) begin
          m_mode   = 2;
          m_anchor = edge_n;
        end
      end else begin
        if (m_int && m_per != 0 && edge_n > m_anchor)
          int_t = ((longint'(edge_n) - m_anchor) %
                   longint'(m_per)) == 0;
        if (ext_t || soft_t) m_anchor = edge_n;
        e_sync = ext_t || soft_t || int_t;
      end
      h3 = h2; h2 = h1; h1 = sync_in;
    end
    #1;
    lit($sformatf("sync@%0d", edge_n), tdd_sync, e_sync);
    lit($sformatf("armed@%0d", edge_n), tdd_sync_armed, m_mode == 1);
    lit($sformatf("run@%0d", edge_n), tdd_sync_running, m_mode == 2);
    if (edge_n < 256) begin
      pl[edge_n] = tdd_sync;
      ar[edge_n] = tdd_sync_armed;
      rn[edge_n] = tdd_sync_running;
    end
  end

  // Inputs set here are first sampled at edge k.
  task automatic at(input int k);
    while (edge_n < k - 1) @(negedge clk);
  endtask

  initial begin
    resetn = 0; tdd_enable = 0; tdd_sync_soft = 0; sync_in = 0;
    tdd_sync_int = 1; tdd_sync_ext = 0; asy_tdd_sync_period = 64'd4;
    at(4);   resetn = 1;
    at(10);  tdd_enable = 1;
    at(25);  tdd_enable = 0; tdd_sync_ext = 1;
             asy_tdd_sync_period = 64'd8;
    at(28);  tdd_enable = 1;
    at(30);  sync_in = 1;
    at(51);  tdd_enable = 0; tdd_sync_ext = 0; sync_in = 0;
             asy_tdd_sync_period = 64'd10;
    at(54);  tdd_enable = 1;
    at(79);  tdd_sync_soft = 1;
    at(80);  tdd_sync_soft = 0;
    at(93);  tdd_enable = 0; asy_tdd_sync_period = 64'd5;
    at(96);  tdd_enable = 1;
    at(106); tdd_sync_soft = 1;
    at(107); tdd_sync_soft = 0;
    at(108); asy_tdd_sync_period = 64'd3;
    at(119); tdd_enable = 0; sync_in = 1;
    at(125); tdd_enable = 1;
    at(136); tdd_enable = 0; tdd_sync_ext = 1;
    at(140); tdd_enable = 1;
    at(147); tdd_sync_soft = 1;
    at(148); tdd_sync_soft = 0;
    at(152); tdd_enable = 0; tdd_sync_ext = 0;
             asy_tdd_sync_period = 64'd0;
    at(155); tdd_enable = 1;
    at(171); tdd_enable = 0; tdd_sync_soft = 1;
    at(172); tdd_sync_soft = 0;
    at(173); tdd_enable = 1;
    at(176); resetn = 0;
    at(178); resetn = 1;
    at(186);

    lit("rst_run", rn[2], 0);
    lit("rst_sync", pl[3], 0);
    lit("s1_run9", rn[9], 0);
    lit("s1_run10", rn[10], 1);
    lit("s1_arm10", ar[10], 0);
    lit("s1_p13", pl[13], 0);
    lit("s1_p14", pl[14], 1);
    lit("s1_p18", pl[18], 1);
    lit("s1_p22", pl[22], 1);
    lit("s2_arm31", ar[31], 1);
    lit("s2_arm32", ar[32], 0);
    lit("s2_p32", pl[32], 1);
    lit("s2_p33", pl[33], 0);
    lit("s2_p40", pl[40], 1);
    lit("s2_p48", pl[48], 1);
    lit("s3_p74", pl[74], 1);
    lit("s3_p79", pl[79], 1);
    lit("s3_p84", pl[84], 0);
    lit("s3_p89", pl[89], 1);
    lit("s4_p106", pl[106], 1);
    lit("s4_p107", pl[107], 0);
    lit("s4_p111", pl[111], 1);
    lit("s4_p114", pl[114], 0);
    lit("s4_p116", pl[116], 1);
    lit("s5_p128", pl[128], 1);
    lit("s5_p131", pl[131], 1);
    lit("s5_p142", pl[142], 0);
    lit("s5_arm146", ar[146], 1);
    lit("s5_p147", pl[147], 1);
    lit("s5_p150", pl[150], 1);
    lit("s6_p160", pl[160], 0);
    lit("s6_run160", rn[160], 1);
    lit("s6_p171", pl[171], 0);
    lit("s6_run171", rn[171], 0);
    lit("s6_run176", rn[176], 0);
    lit("s6_run178", rn[178], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
